// File: rtl/adder_axil_master.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// adder_axil_master
//
// AXI4-Lite master that runs one fixed command sequence per start pulse:
//   write op_a to 0x00, write op_b to 0x04, read the sum back from 0x08.
// The read data is presented on result together with the first non-OKAY
// response code seen (or 2'b11 if any handshake waited TIMEOUT cycles).
//
// Ports
//   m0_axi_aclk, m0_axi_aresetn : clock, asynchronous active-low reset
//   start, op_a, op_b           : command request and operands (IDLE only)
//   busy, done                  : sequence in progress / one-cycle completion
//   result, err                 : read-back sum and status, held until next done
//   m0_axi_aw*, m0_axi_w*       : write address / write data channels
//   m0_axi_b*                   : write response channel
//   m0_axi_ar*, m0_axi_r*       : read address / read data channels
// ----------------------------------------------------------------------------
module adder_axil_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    m0_axi_aclk,
    input  logic                    m0_axi_aresetn,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [1:0]              err,
    output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
    output logic                    m0_axi_awvalid,
    input  logic                    m0_axi_awready,
    output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
    output logic                    m0_axi_wvalid,
    input  logic                    m0_axi_wready,
    input  logic [1:0]              m0_axi_bresp,
    input  logic                    m0_axi_bvalid,
    output logic                    m0_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
    output logic                    m0_axi_arvalid,
    input  logic                    m0_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
    input  logic [1:0]              m0_axi_rresp,
    input  logic                    m0_axi_rvalid,
    output logic                    m0_axi_rready
);

    // Counter only needs to reach TIMEOUT-1: the timeout fires on that cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LP_WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_A   = '0;
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_B   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_SUM = ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RESP_A,
        RESP_B,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_wait;
    logic                    w_wait_state;
    logic                    w_wait_last;
    logic                    w_wr_done;
    logic                    w_timeout;

    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_wvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [1:0]              r_err;
    logic [DATA_WIDTH-1:0]   r_op_b;

    // Keep the first non-OKAY code; later responses never overwrite it.
    function automatic logic [1:0] f_merge_err(input logic [1:0] cur, input logic [1:0] resp);
        return (cur == 2'b00) ? resp : cur;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
        if (!m0_axi_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_timeout     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        m0_axi_bready = 1'b0;
        m0_axi_rready = 1'b0;
        // A channel counts as finished once its valid has dropped or is
        // handshaking this cycle, so AW and W may complete in either order.
        w_wr_done     = (!r_awvalid || m0_axi_awready) && (!r_wvalid || m0_axi_wready);

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = WR_A;
                end
            end
            WR_A, WR_B: begin
                if (w_wr_done) begin
                    w_next = (r_state == WR_A) ? RESP_A : RESP_B;
                end else if (w_wait_last) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            RESP_A, RESP_B: begin
                m0_axi_bready = 1'b1;
                if (m0_axi_bvalid) begin
                    w_next = (r_state == RESP_A) ? WR_B : RD_ADDR;
                end else if (w_wait_last) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            RD_ADDR: begin
                if (m0_axi_arready) begin
                    w_next = RD_DATA;
                end else if (w_wait_last) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            RD_DATA: begin
                m0_axi_rready = 1'b1;
                if (m0_axi_rvalid) begin
                    w_next = DONE;
                end else if (w_wait_last) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state wait counter, cleared on every state change
    // ------------------------------------------------------------------
    assign w_wait_state = (r_state != IDLE) && (r_state != DONE);
    assign w_wait_last  = (r_wait == LP_WAIT_LAST);

    always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
        if (!m0_axi_aresetn) begin
            r_wait <= '0;
        end else if (!w_wait_state || (w_next != r_state)) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Channel registers, status and result
    // Address/data for the next transfer are loaded on the edge that enters
    // the transfer state, so they are stable for the whole valid period.
    // ------------------------------------------------------------------
    always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
        if (!m0_axi_aresetn) begin
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wvalid  <= 1'b0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_result  <= '0;
            r_err     <= '0;
            r_op_b    <= '0;
        end else if (w_timeout) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_err     <= 2'b11;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_b    <= op_b;
                        r_err     <= '0;
                        r_awaddr  <= LP_ADDR_A;
                        r_wdata   <= op_a;
                        r_wstrb   <= '1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                WR_A, WR_B: begin
                    if (m0_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m0_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                end
                RESP_A: begin
                    if (m0_axi_bvalid) begin
                        r_err     <= f_merge_err(r_err, m0_axi_bresp);
                        r_awaddr  <= LP_ADDR_B;
                        r_wdata   <= r_op_b;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                RESP_B: begin
                    if (m0_axi_bvalid) begin
                        r_err     <= f_merge_err(r_err, m0_axi_bresp);
                        r_araddr  <= LP_ADDR_SUM;
                        r_arvalid <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (m0_axi_arready) begin
                        r_arvalid <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (m0_axi_rvalid) begin
                        r_result <= m0_axi_rdata;
                        r_err    <= f_merge_err(r_err, m0_axi_rresp);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m0_axi_awaddr  = r_awaddr;
    assign m0_axi_awvalid = r_awvalid;
    assign m0_axi_wdata   = r_wdata;
    assign m0_axi_wstrb   = r_wstrb;
    assign m0_axi_wvalid  = r_wvalid;
    assign m0_axi_araddr  = r_araddr;
    assign m0_axi_arvalid = r_arvalid;
    assign result         = r_result;
    assign err            = r_err;

endmodule

// File: doc/adder_axil_master.md
ADDER_AXIL_MASTER -- requirements
Module: adder_axil_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, AXI4-Lite address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per handshake.
REQ-004 SHALL have port m0_axi_aclk  in  1  single clock.
REQ-005 SHALL have port m0_axi_aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle command request.
REQ-007 SHALL have port op_a, op_b  in  DATA_WIDTH each  operands, sampled on accepted start.
REQ-008 SHALL have port busy  out  1  high while not IDLE.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port result  out  DATA_WIDTH  read-back sum, held until next done.
REQ-011 SHALL have port err  out  2  first non-OKAY response code, or 2'b11 on timeout, held until next done.
REQ-012 SHALL have ports m0_axi_awaddr  out  ADDR_WIDTH, m0_axi_awvalid  out  1, m0_axi_awready  in  1.
REQ-013 SHALL have ports m0_axi_wdata  out  DATA_WIDTH, m0_axi_wstrb  out  DATA_WIDTH/8, m0_axi_wvalid  out  1, m0_axi_wready  in  1.
REQ-014 SHALL have ports m0_axi_bresp  in  2, m0_axi_bvalid  in  1, m0_axi_bready  out  1.
REQ-015 SHALL have ports m0_axi_araddr  out  ADDR_WIDTH, m0_axi_arvalid  out  1, m0_axi_arready  in  1.
REQ-016 SHALL have ports m0_axi_rdata  in  DATA_WIDTH, m0_axi_rresp  in  2, m0_axi_rvalid  in  1, m0_axi_rready  out  1.

Function
REQ-017 SHALL implement states IDLE, WR_A, WR_B, RESP_A, RESP_B, RD_ADDR, RD_DATA, DONE.
REQ-018 SHALL accept start only in IDLE, latching op_a/op_b, clearing err, entering WR_A next cycle; start while busy ignored.
REQ-019 In WR_A SHALL drive awaddr=0x00, wdata=op_a; in WR_B awaddr=0x04, wdata=op_b; wstrb all ones in both.
REQ-020 SHALL assert awvalid and wvalid together, drop each independently on its own valid&ready, move to RESP_x when both channels have handshaken (same or different cycles).
REQ-021 SHALL never deassert a valid before its ready, nor change addr/data while valid is high.
REQ-022 In RESP_x SHALL hold bready=1; on bvalid record bresp into err if err==0 and bresp!=0; RESP_A->WR_B, RESP_B->RD_ADDR.
REQ-023 In RD_ADDR SHALL drive araddr=0x08, arvalid=1 until arready, then RD_DATA.
REQ-024 In RD_DATA SHALL hold rready=1; on rvalid capture rdata into result, record rresp as per REQ-022, go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then IDLE; min start-to-done 7 cycles with always-ready slave.
REQ-026 A wait counter SHALL reset on each state entry; reaching TIMEOUT in any wait state SHALL set err=2'b11, drop all valids/readies, go to DONE; result unchanged.
REQ-027 Error responses SHALL NOT abort the sequence; remaining transfers still complete.
REQ-028 bready/rready SHALL be low outside RESP_x/RD_DATA; stray bvalid/rvalid there ignored.

Reset
REQ-029 On aresetn low, asynchronously: state=IDLE; all valid/ready outputs, busy, done=0; result, err, addresses, wdata, wstrb, latched operands=0; counter=0.
REQ-030 Reset mid-transaction SHALL abandon it with no done pulse; first start after release begins a fresh sequence.

Verification
REQ-031 Always-ready OKAY slave, op_a=5, op_b=7, slave returns 12 -> writes 0x00=5, 0x04=7, read 0x08, result=12, err=0, done 7 cycles after start.
REQ-032 awready 3 cycles after wready on WR_A -> wvalid drops at its handshake, awvalid held stable, sequence continues correctly.
REQ-033 bresp=2'b10 on WR_B, rresp=0 -> read still done, err=2'b10, result captured.
REQ-034 arready held low, TIMEOUT=255 -> done after 255 wait cycles, err=2'b11, result retains prior value.
REQ-035 start pulsed while busy, then aresetn low during RD_DATA -> extra start ignored; all outputs 0, no done, next start completes normally.
